// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared op, state and encoding definitions for alu_mc
package alu_mc_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_ILL
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_SLT = 4'b0100;
  localparam logic [3:0] F_SLL = 4'b0101;
  localparam logic [3:0] F_SRL = 4'b0110;
  localparam logic [3:0] F_MUL = 4'b0111;
  localparam logic [1:0] AOP_RTYPE = 2'b00;
  localparam logic [1:0] AOP_SLTI  = 2'b01;
  localparam logic [1:0] AOP_BEQ   = 2'b10;
  localparam logic [1:0] AOP_ADDI  = 2'b11;
endpackage

// File: rtl/alu_mc_dec.sv
// alu_mc_dec: combinational aluop/funct decode to an alu_op_e
module alu_mc_dec
  import alu_mc_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int MUL_EN  = 1
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output alu_op_e            op
);
  always_comb begin
    op = OP_ILL;
    case (aluop)
      AOP_SLTI: op = OP_SLT;
      AOP_BEQ:  op = OP_SUB;
      AOP_ADDI: op = OP_ADD;
      default: begin
        case (funct)
          FUNCT_W'(F_ADD): op = OP_ADD;
          FUNCT_W'(F_SUB): op = OP_SUB;
          FUNCT_W'(F_AND): op = OP_AND;
          FUNCT_W'(F_OR):  op = OP_OR;
          FUNCT_W'(F_SLT): op = OP_SLT;
          FUNCT_W'(F_SLL): op = OP_SLL;
          FUNCT_W'(F_SRL): op = OP_SRL;
          FUNCT_W'(F_MUL): op = MUL_EN != 0 ? OP_MUL : OP_ILL;
          default:         op = OP_ILL;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered single-cycle ops and shift-add multiply
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 4,
  parameter int MUL_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state, state_n;
  alu_op_e op;
  logic accept;
  logic [WIDTH-1:0] res_c, mcand, mplier, acc, acc_n;
  logic [CW-1:0] cnt;
  alu_mc_dec #(.FUNCT_W(FUNCT_W), .MUL_EN(MUL_EN)) u_dec (
    .aluop(aluop),
    .funct(funct),
    .op(op)
  );
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    res_c = '0;
    case (op)
      OP_ADD: res_c = a + b;
      OP_SUB: res_c = a - b;
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_SLT: res_c = WIDTH'($signed(a) < $signed(b));
      OP_SLL: res_c = a << b[SW-1:0];
      OP_SRL: res_c = a >> b[SW-1:0];
      default: res_c = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    state_n = accept ? (op == OP_MUL ? MUL : DONE)
            : state == MUL ? (cnt == CW'(1) ? DONE : MUL)
            : state == DONE && out_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
        if (op != OP_MUL) begin
          result  <= res_c;
          zero    <= res_c == '0;
          illegal <= op == OP_ILL;
        end
      end else if (state == MUL) begin
        acc    <= acc_n;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result  <= acc_n;
          zero    <= acc_n == '0;
          illegal <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [1:0] aluop = 2'b00;
  logic [3:0] funct = 4'b0000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic in_ready0, out_valid0, zero0, illegal0;
  logic [31:0] result0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_mc #(.WIDTH(32), .FUNCT_W(4), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );
  alu_mc #(.WIDTH(32), .FUNCT_W(4), .MUL_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .out_valid(out_valid0),
    .out_ready(out_ready), .result(result0), .zero(zero0), .illegal(illegal0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    aluop = op;
    funct = f;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    aluop = 2'b00;
    funct = 4'b1110;
    a = 32'hdead_beef;
    b = 32'h1234_5678;
  endtask
  task automatic op1(input string tag, input logic [1:0] op, input logic [3:0] f,
                     input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    issue(op, f, x, y);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask
  initial begin
    int lat;
    int ir_bad;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    op1("sub", 2'b00, 4'b0001, 32'd5, 32'd7, 32'hffff_fffe);
    op1("slt_lt", 2'b00, 4'b0100, 32'd5, 32'd7, 32'd1);
    op1("slt_ge", 2'b00, 4'b0100, 32'd7, 32'd5, 32'd0);
    op1("slt_neg", 2'b00, 4'b0100, 32'hffff_ffff, 32'd1, 32'd1);
    op1("add_wrap", 2'b00, 4'b0000, 32'hffff_ffff, 32'd1, 32'd0);
    op1("and", 2'b00, 4'b0010, 32'hf0f0_ff00, 32'h0ff0_f0f0, 32'h00f0_f000);
    op1("or", 2'b00, 4'b0011, 32'hf000_0001, 32'h0000_0f00, 32'hf000_0f01);
    op1("sll", 2'b00, 4'b0101, 32'd1, 32'd35, 32'd8);
    op1("srl", 2'b00, 4'b0110, 32'h8000_0000, 32'd4, 32'h0800_0000);
    op1("slti", 2'b01, 4'b1111, 32'd3, 32'd2, 32'd0);
    op1("beq", 2'b10, 4'b1111, 32'd4, 32'd4, 32'd0);
    op1("addi", 2'b11, 4'b1111, 32'd10, 32'd20, 32'd30);
    issue(2'b00, 4'b1111, 32'd3, 32'd4);
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_result", result, 32'd0);
    chk("ill_zero", 32'(zero), 32'd1);
    issue(2'b00, 4'b0111, 32'h0001_0003, 32'h0000_0005);
    chk("nomul_valid", 32'(out_valid0), 32'd1);
    chk("nomul_illegal", 32'(illegal0), 32'd1);
    chk("nomul_result", result0, 32'd0);
    chk("nomul_zero", 32'(zero0), 32'd1);
    lat = 0;
    ir_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_latency", 32'(lat), 32'd32);
    chk("mul_ready_low", 32'(ir_bad), 32'd0);
    chk("mul_result", result, 32'h0005_000f);
    chk("mul_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_after", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    issue(2'b00, 4'b0000, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        aluop = 2'b00;
        funct = 4'b0000;
        a = 32'd100;
        b = 32'd100;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_result", result, 32'd3);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    op1("b2b_sub", 2'b00, 4'b0001, 32'd9, 32'd9, 32'd0);
    issue(2'b00, 4'b0111, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_result", result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mid_no_valid", 32'(seen), 32'd0);
    op1("post_rst_add", 2'b00, 4'b0000, 32'd2, 32'd3, 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
